// File: rtl/clock_set_ctrl_if.sv
// Counter bus between the time-set controller and the sec/min/hour counters.
// The controller grants one counter at a time onto the shared read bus and
// issues load strobes with the value to load.
interface clock_set_ctrl_if;
    logic [5:0] databus;
    logic       en_sec;
    logic       en_min;
    logic       en_hour;
    logic       ld_sec;
    logic       ld_min;
    logic       ld_hour;
    logic [5:0] load_data;
    logic       run;

    modport master (
        input  databus,
        output en_sec, en_min, en_hour,
        output ld_sec, ld_min, ld_hour,
        output load_data,
        output run
    );

    modport slave (
        output databus,
        input  en_sec, en_min, en_hour,
        input  ld_sec, ld_min, ld_hour,
        input  load_data,
        input  run
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-set controller for a digital clock.
// Scans the sec/min/hour counters over a shared bus into display registers and
// runs a mode/increment button state machine that edits hour, minute and second
// in turn, loading each edited value back into its counter with a one-cycle strobe.
// Set mode aborts without loading after TIMEOUT seconds with no button press.
module clock_set_ctrl #(
    parameter int HOUR_MOD = 24,
    parameter int MIN_MOD  = 60,
    parameter int TIMEOUT  = 10
) (
    input  logic                    clk,
    input  logic                    clear,
    input  logic                    btn_mode,
    input  logic                    btn_inc,
    input  logic                    tick_1hz,
    clock_set_ctrl_if.master        bus,
    output logic [1:0]              state,
    output logic [5:0]              disp_sec,
    output logic [5:0]              disp_min,
    output logic [4:0]              disp_hour,
    output logic [5:0]              edit_val
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_SET_HOUR = 2'b01,
        ST_SET_MIN  = 2'b10,
        ST_SET_SEC  = 2'b11
    } state_t;

    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [5:0] HOUR_LAST = 6'(HOUR_MOD - 1);
    localparam logic [5:0] MIN_LAST  = 6'(MIN_MOD - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    state_t        state_r;
    logic          run_r;
    logic          en_sec_r;
    logic          en_min_r;
    logic          en_hour_r;
    logic          ld_sec_r;
    logic          ld_min_r;
    logic          ld_hour_r;
    logic [5:0]    load_data_r;
    logic [5:0]    edit_r;
    logic [TW-1:0] tcount;
    logic          mode_q;
    logic          inc_q;

    logic          mode_press;
    logic          inc_press;
    logic          timeout_hit;
    logic [5:0]    edit_max;
    logic [5:0]    edit_next;

    // Press detection, timeout compare and wrapped increment of the edited field.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        mode_press  = 1'b0;
        inc_press   = 1'b0;
        timeout_hit = 1'b0;
        edit_max    = MIN_LAST;
        edit_next   = 6'd0;

        mode_press  = btn_mode & ~mode_q;
        inc_press   = btn_inc & ~inc_q;
        timeout_hit = tick_1hz && (tcount == TCNT_LAST);
        if (state_r == ST_SET_HOUR) begin
            edit_max = HOUR_LAST;
        end
        edit_next = (edit_r == edit_max) ? 6'd0 : edit_r + 6'd1;
    end

    // Bus grant rotates sec -> min -> hour -> sec every cycle.
    always_ff @(posedge clk or posedge clear) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (clear) begin
            {en_hour_r, en_min_r, en_sec_r} <= 3'b001;
        end else begin
            {en_hour_r, en_min_r, en_sec_r} <= {en_min_r, en_sec_r, en_hour_r};
        end
    end

    // Capture the granted counter's bus value into its display register.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            disp_sec  <= 6'd0;
            disp_min  <= 6'd0;
            disp_hour <= 5'd0;
        end else begin
            if (en_sec_r) begin
                disp_sec <= bus.databus;
            end
            if (en_min_r) begin
                disp_min <= bus.databus;
            end
            if (en_hour_r) begin
                disp_hour <= bus.databus[4:0];
            end
        end
    end

    // Set-mode state machine with registered run, strobes, load value and edit value.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r     <= ST_RUN;
            run_r       <= 1'b1;
            ld_sec_r    <= 1'b0;
            ld_min_r    <= 1'b0;
            ld_hour_r   <= 1'b0;
            load_data_r <= 6'd0;
            edit_r      <= 6'd0;
            tcount      <= '0;
            mode_q      <= 1'b0;
            inc_q       <= 1'b0;
        end else begin
            mode_q      <= btn_mode;
            inc_q       <= btn_inc;
            ld_sec_r    <= 1'b0;
            ld_min_r    <= 1'b0;
            ld_hour_r   <= 1'b0;
            load_data_r <= 6'd0;

            if (state_r == ST_RUN) begin
                // Ticks are ignored while running; counting resumes from the cycle after any SET exit.
                run_r  <= 1'b1;
                tcount <= '0;
                edit_r <= 6'd0;
                if (mode_press) begin
                    state_r <= ST_SET_HOUR;
                    run_r   <= 1'b0;
                    edit_r  <= {1'b0, disp_hour};
                end
            end else begin
                // Run stays low through the final strobe cycle so the counter loads before it counts.
                run_r <= 1'b0;
                if (mode_press) begin
                    // Mode wins over a coincident increment, which is dropped.
                    tcount      <= '0;
                    load_data_r <= edit_r;
                    case (state_r)
                        ST_SET_HOUR: begin
                            ld_hour_r <= 1'b1;
                            state_r   <= ST_SET_MIN;
                            edit_r    <= disp_min;
                        end
                        ST_SET_MIN: begin
                            ld_min_r <= 1'b1;
                            state_r  <= ST_SET_SEC;
                            edit_r   <= disp_sec;
                        end
                        default: begin
                            ld_sec_r <= 1'b1;
                            state_r  <= ST_RUN;
                            edit_r   <= 6'd0;
                        end
                    endcase
                end else if (inc_press) begin
                    tcount <= '0;
                    edit_r <= edit_next;
                end else if (timeout_hit) begin
                    // Abort: nothing is loaded and the edit is discarded.
                    tcount  <= '0;
                    state_r <= ST_RUN;
                    edit_r  <= 6'd0;
                end else if (tick_1hz) begin
                    tcount <= tcount + TW'(1);
                end
            end
        end
    end

    assign bus.en_sec    = en_sec_r;
    assign bus.en_min    = en_min_r;
    assign bus.en_hour   = en_hour_r;
    assign bus.ld_sec    = ld_sec_r;
    assign bus.ld_min    = ld_min_r;
    assign bus.ld_hour   = ld_hour_r;
    assign bus.load_data = load_data_r;
    assign bus.run       = run_r;
    assign state         = state_r;
    assign edit_val      = edit_r;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed testbench for clock_set_ctrl: bus scan, full set sequence, minute
// wrap, simultaneous press, timeout and asynchronous clear.
module tb_clock_set_ctrl;

    logic       clk;
    logic       clear;
    logic       btn_mode;
    logic       btn_inc;
    logic       tick_1hz;
    logic [1:0] state;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic [4:0] disp_hour;
    logic [5:0] edit_val;

    logic [5:0] sec_val;
    logic [5:0] min_val;
    logic [5:0] hour_val;

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;
    int onehot_err = 0;
    int ld_data_err = 0;
    int strobes_before;

    logic [2:0] snap_ld;
    logic [5:0] snap_data;
    logic [1:0] snap_state;
    logic       snap_run;

    clock_set_ctrl_if bus ();

    clock_set_ctrl dut (
        .clk       (clk),
        .clear     (clear),
        .btn_mode  (btn_mode),
        .btn_inc   (btn_inc),
        .tick_1hz  (tick_1hz),
        .bus       (bus),
        .state     (state),
        .disp_sec  (disp_sec),
        .disp_min  (disp_min),
        .disp_hour (disp_hour),
        .edit_val  (edit_val)
    );

    // Counter model: the granted counter drives its value, zero when none granted.
    assign bus.databus = bus.en_sec  ? sec_val  :
                         bus.en_min  ? min_val  :
                         bus.en_hour ? hour_val : 6'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle monitor: counts strobes, grant one-hot violations and stray load_data.
    always @(posedge clk) begin
        #1;
        if (!clear) begin
            if (!$onehot({bus.en_hour, bus.en_min, bus.en_sec})) onehot_err++;
            if (bus.ld_sec || bus.ld_min || bus.ld_hour) strobe_cnt++;
            else if (bus.load_data !== 6'd0) ld_data_err++;
            if ((32'(bus.ld_sec) + 32'(bus.ld_min) + 32'(bus.ld_hour)) > 1) ld_data_err++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Raise buttons, snapshot the strobe cycle, release and settle one cycle.
    task automatic press(input logic m, input logic i);
        btn_mode = m;
        btn_inc  = i;
        @(negedge clk);
        snap_ld    = {bus.ld_hour, bus.ld_min, bus.ld_sec};
        snap_data  = bus.load_data;
        snap_state = state;
        snap_run   = bus.run;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clear    = 1'b1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        tick_1hz = 1'b0;
        sec_val  = 6'd0;
        min_val  = 6'd0;
        hour_val = 6'd0;
        cycles(2);

        // Reset state
        chk("rst_state",   32'(state), 0);
        chk("rst_run",     32'(bus.run), 1);
        chk("rst_en",      32'({bus.en_hour, bus.en_min, bus.en_sec}), 32'b001);
        chk("rst_ld",      32'({bus.ld_hour, bus.ld_min, bus.ld_sec}), 0);
        chk("rst_ldata",   32'(bus.load_data), 0);
        chk("rst_edit",    32'(edit_val), 0);
        chk("rst_disp",    32'({disp_hour, disp_min, disp_sec}), 0);

        // Scan: grant order and display capture within 3 cycles
        sec_val  = 6'd17;
        min_val  = 6'd42;
        hour_val = 6'd9;
        clear    = 1'b0;
        @(negedge clk);
        chk("grant_1", 32'({bus.en_hour, bus.en_min, bus.en_sec}), 32'b010);
        @(negedge clk);
        chk("grant_2", 32'({bus.en_hour, bus.en_min, bus.en_sec}), 32'b100);
        @(negedge clk);
        chk("grant_3", 32'({bus.en_hour, bus.en_min, bus.en_sec}), 32'b001);
        chk("scan_sec",  32'(disp_sec), 17);
        chk("scan_min",  32'(disp_min), 42);
        chk("scan_hour", 32'(disp_hour), 9);

        // Full set sequence from hour 22
        hour_val = 6'd22;
        cycles(3);
        chk("set_disp_hour", 32'(disp_hour), 22);
        press(1'b1, 1'b0);
        chk("enter_state", 32'(snap_state), 1);
        chk("enter_run",   32'(snap_run), 0);
        chk("enter_edit",  32'(edit_val), 22);
        press(1'b0, 1'b1);
        chk("hour_inc_23", 32'(edit_val), 23);
        press(1'b0, 1'b1);
        chk("hour_wrap_0", 32'(edit_val), 0);
        press(1'b0, 1'b1);
        chk("hour_inc_1",  32'(edit_val), 1);
        press(1'b1, 1'b0);
        chk("ld_hour",      32'(snap_ld), 32'b100);
        chk("ld_hour_data", 32'(snap_data), 1);
        chk("to_min_state", 32'(snap_state), 2);
        chk("to_min_edit",  32'(edit_val), 42);
        chk("no_strobe_after", 32'({bus.ld_hour, bus.ld_min, bus.ld_sec}), 0);
        press(1'b0, 1'b1);
        chk("min_inc_43", 32'(edit_val), 43);
        press(1'b1, 1'b0);
        chk("ld_min",       32'(snap_ld), 32'b010);
        chk("ld_min_data",  32'(snap_data), 43);
        chk("to_sec_state", 32'(snap_state), 3);
        chk("to_sec_edit",  32'(edit_val), 17);
        press(1'b1, 1'b0);
        chk("ld_sec",        32'(snap_ld), 32'b001);
        chk("ld_sec_data",   32'(snap_data), 17);
        chk("back_run_st",   32'(snap_state), 0);
        chk("strobe_run_lo", 32'(snap_run), 0);
        chk("run_after",     32'(bus.run), 1);
        chk("edit_run_zero", 32'(edit_val), 0);

        // Minute wrap 58 -> 59 -> 0
        min_val = 6'd58;
        cycles(3);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("wrap_ld_hour_data", 32'(snap_data), 22);
        chk("wrap_edit_58", 32'(edit_val), 58);
        press(1'b0, 1'b1);
        chk("min_inc_59", 32'(edit_val), 59);
        press(1'b0, 1'b1);
        chk("min_wrap_0", 32'(edit_val), 0);
        press(1'b1, 1'b0);
        chk("wrap_ld_min_data", 32'(snap_data), 0);
        press(1'b1, 1'b0);
        chk("wrap_exit", 32'(state), 0);

        // Simultaneous mode and inc: increment discarded
        hour_val = 6'd5;
        cycles(3);
        press(1'b1, 1'b0);
        chk("simul_edit_5", 32'(edit_val), 5);
        press(1'b1, 1'b1);
        chk("simul_ld",    32'(snap_ld), 32'b100);
        chk("simul_data",  32'(snap_data), 5);
        chk("simul_state", 32'(snap_state), 2);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("simul_exit", 32'(state), 0);

        // Ticks in RUN are ignored; press restarts the count; 10 ticks abort
        for (int i = 0; i < 12; i++) pulse_tick();
        chk("run_ticks_state", 32'(state), 0);
        press(1'b1, 1'b0);
        strobes_before = strobe_cnt;
        for (int i = 0; i < 9; i++) pulse_tick();
        chk("tmo_9_hold", 32'(state), 1);
        press(1'b0, 1'b1);
        chk("tmo_inc_edit", 32'(edit_val), 6);
        for (int i = 0; i < 9; i++) pulse_tick();
        chk("tmo_restart_hold", 32'(state), 1);
        pulse_tick();
        chk("tmo_state",   32'(state), 0);
        chk("tmo_run",     32'(bus.run), 1);
        chk("tmo_edit",    32'(edit_val), 0);
        chk("tmo_nostrobe", 32'(strobe_cnt), 32'(strobes_before));

        // Asynchronous clear in SET_MIN between edges
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("clr_pre_state", 32'(state), 2);
        strobes_before = strobe_cnt;
        #3;
        clear = 1'b1;
        #1;
        chk("clr_state", 32'(state), 0);
        chk("clr_run",   32'(bus.run), 1);
        chk("clr_en",    32'({bus.en_hour, bus.en_min, bus.en_sec}), 32'b001);
        chk("clr_edit",  32'(edit_val), 0);
        chk("clr_ld",    32'({bus.ld_hour, bus.ld_min, bus.ld_sec}), 0);
        @(negedge clk);
        clear = 1'b0;
        cycles(2);
        chk("clr_nostrobe", 32'(strobe_cnt), 32'(strobes_before));
        chk("clr_still_run", 32'(state), 0);

        // Whole-run invariants
        chk("grant_onehot", 32'(onehot_err), 0);
        chk("ldata_idle_zero", 32'(ld_data_err), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
